segment_reader: RTL and testbench
=================================

# segment_reader

Sequential decoder for the 7-segment bus that the display path drives: it watches a 7-bit segment pattern, filters glitches, decodes the stable glyph back to a 4-bit hex digit, and detects a blinking display. It is the receive-side counterpart of the digit/effects generator. It is used for loopback self-test and for reading a neighbouring design's display output through the user I/O pins.

## Interface
Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples required before a pattern is accepted; legal range 2..15.
- BLINK_MAX, 25000: maximum length in cycles of one blink half-period; legal range 4..2^20.

Ports:
- i_clk  input  1  clock; all logic is clocked on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_segment  input  7  segment pattern, active-high, bit0=a … bit6=g.
- o_digit  output  4  last accepted valid hex digit.
- o_valid  output  1  accepted pattern is a legal hex glyph.
- o_blank  output  1  accepted pattern is all-off (0x00).
- o_invalid  output  1  accepted pattern is non-blank and not a glyph.
- o_change  output  1  one-cycle pulse when o_digit takes a new value.
- o_blinking  output  1  a blinking display is detected.

## Operation
- Sampling: r_sample <= i_segment on every edge. Stability count: cleared to 0 when i_segment != r_sample; otherwise incremented, saturating at 15.
- Acceptance: when count >= STABLE_CYCLES-1, r_sample becomes the accepted pattern on the next edge. At most one of o_valid, o_blank, o_invalid is high.
- Glyph table (hex in → digit out): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Any other nonzero pattern is invalid.
- o_digit updates only on an accepted valid glyph. It holds through blank and invalid.
- o_change pulses on a valid acceptance whose digit differs from o_digit. It also pulses on the first valid acceptance after reset, even if the digit is 0.
- Phase counter: cleared whenever the accepted pattern changes value. Otherwise it increments, saturating at BLINK_MAX. Its width is $clog2(BLINK_MAX+1).
- Blink FSM. Events are accepted-pattern changes; "sat" means the phase counter equals BLINK_MAX.
  - IDLE: valid D → ON(D).
  - ON(D): blank before sat → OFF; blank at sat → IDLE; valid D' != D → ON(D'); invalid → IDLE.
  - OFF: valid D before sat → BLINK; sat → IDLE; valid D' != D → ON(D'); invalid → IDLE.
  - BLINK: D↔blank alternation before sat → stays in BLINK; sat in either half → IDLE; valid D' != D → ON(D'); invalid → IDLE.
  - o_blinking = (state == BLINK).
- Reset mid-operation: all state returns to reset values on the next edge, and any partial stability or blink history is discarded.

## Timing
- Reset values: o_digit=0, o_valid=0, o_blank=0, o_invalid=0, o_change=0, o_blinking=0, r_sample=0, count=0, FSM=IDLE, phase=0.
- Latency: a pattern first present before edge 1 and held is reflected on the outputs after edge STABLE_CYCLES+1 (5 cycles at default). o_change is asserted in that same cycle.
- A pattern held for only STABLE_CYCLES-1 cycles is never accepted, and the outputs are unchanged.
- Re-accepting the same pattern as the current accepted pattern produces no change event, no o_change pulse, and no phase clear.
- o_blinking rises on the edge that accepts the returning digit D after OFF. It falls on the edge where phase reaches BLINK_MAX, or on a digit change or invalid acceptance.

## Configuration
- SEGMENT_READER_BLINK_EN defined: the phase counter and blink FSM are compiled in, and they behave as above.
- SEGMENT_READER_BLINK_EN undefined: the phase counter and FSM are removed, o_blinking is tied to 0, and BLINK_MAX is unused. All other behaviour is identical.

## Test plan
Use STABLE_CYCLES=4 and BLINK_MAX=64 unless noted.
- Reset, then hold i_segment=0x5B → o_valid=1 and o_digit=2 after edge 5, with o_change high for exactly one cycle; o_blank=o_invalid=0 throughout.
- After 0x06 is accepted: 0x4F for 3 cycles then back to 0x06 → no output change and no o_change. Separately, 0x49 held 4 cycles → o_invalid=1, o_valid=0, o_digit stays 1.
- Sweep all 16 glyphs, each held 6 cycles → o_digit follows 0..F with 16 o_change pulses. 0x00 held → o_blank=1, o_digit holds F.
- Blink test: 0x7F/0x00 alternating every 20 cycles → o_blinking=1 on the second 0x7F acceptance. Then hold 0x7F → o_blinking falls when phase reaches 64. Repeat with 80-cycle halves → o_blinking stays 0.
- Assert i_rst_n=0 for one edge while blinking → all outputs at reset values on the next edge. Build without SEGMENT_READER_BLINK_EN and rerun the blink test → o_blinking stays 0 and decode results are unchanged.

Source files
------------

// File: rtl/segment_reader.sv
// Receive-side 7-segment decoder: deglitches the segment bus, decodes the stable glyph to hex, flags blinking.
// Define SEGMENT_READER_BLINK_EN to build in the phase counter and blink FSM; otherwise o_blinking is held low.
module segment_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLINK_MAX     = 25000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_segment,
    output logic [3:0] o_digit,
    output logic       o_valid,
    output logic       o_blank,
    output logic       o_invalid,
    output logic       o_change,
    output logic       o_blinking
);

    localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CYCLES - 1);

    logic [6:0] r_sample;
    logic [3:0] count;
    logic       have_digit;
    logic       accept;
    logic       seg_valid;
    logic       seg_blank;
    logic       seg_invalid;
    logic [3:0] seg_digit;

    always_comb begin
        seg_valid = 1'b1;
        seg_digit = '0;
        case (r_sample)
            7'h3F: seg_digit = 4'h0;
            7'h06: seg_digit = 4'h1;
            7'h5B: seg_digit = 4'h2;
            7'h4F: seg_digit = 4'h3;
            7'h66: seg_digit = 4'h4;
            7'h6D: seg_digit = 4'h5;
            7'h7D: seg_digit = 4'h6;
            7'h07: seg_digit = 4'h7;
            7'h7F: seg_digit = 4'h8;
            7'h6F: seg_digit = 4'h9;
            7'h77: seg_digit = 4'hA;
            7'h7C: seg_digit = 4'hB;
            7'h39: seg_digit = 4'hC;
            7'h5E: seg_digit = 4'hD;
            7'h79: seg_digit = 4'hE;
            7'h71: seg_digit = 4'hF;
            default: seg_valid = 1'b0;
        endcase
    end

    assign seg_blank   = (r_sample == '0);
    assign seg_invalid = !seg_valid && !seg_blank;
    assign accept      = (count >= ACCEPT_AT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sample   <= '0;
            count      <= '0;
            have_digit <= 1'b0;
            o_digit    <= '0;
            o_valid    <= 1'b0;
            o_blank    <= 1'b0;
            o_invalid  <= 1'b0;
            o_change   <= 1'b0;
        end else begin
            r_sample <= i_segment;
            if (i_segment != r_sample)
                count <= '0;
            else if (count != 4'd15)
                count <= count + 4'd1;
            o_change <= 1'b0;
            if (accept) begin
                o_valid   <= seg_valid;
                o_blank   <= seg_blank;
                o_invalid <= seg_invalid;
                if (seg_valid) begin
                    o_digit    <= seg_digit;
                    have_digit <= 1'b1;
                    o_change   <= !have_digit || (seg_digit != o_digit);
                end
            end
        end
    end

`ifdef SEGMENT_READER_BLINK_EN
    localparam int unsigned PW = $clog2(BLINK_MAX + 1);
    localparam logic [PW-1:0] PHASE_MAX = PW'(BLINK_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_BLINK} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] phase, phase_nxt;
    logic [3:0]    on_digit, on_digit_nxt;
    logic [6:0]    acc_pat;
    logic          ev;
    logic          sat;
    logic          timeout;

    assign ev        = accept && (r_sample != acc_pat);
    assign sat       = (phase == PHASE_MAX);
    assign phase_nxt = ev ? '0 : (sat ? phase : phase + PW'(1));
    // Timeout looks at the next phase so blinking drops on the edge phase saturates.
    assign timeout   = !ev && (phase_nxt == PHASE_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            phase    <= '0;
            on_digit <= '0;
            acc_pat  <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            on_digit <= on_digit_nxt;
            if (accept)
                acc_pat <= r_sample;
        end
    end

    always_comb begin
        state_nxt    = state;
        on_digit_nxt = on_digit;
        case (state)
            ST_IDLE: begin
                if (ev && seg_valid) begin
                    state_nxt    = ST_ON;
                    on_digit_nxt = seg_digit;
                end
            end
            ST_ON: begin
                if (ev) begin
                    if (seg_blank)
                        state_nxt = sat ? ST_IDLE : ST_OFF;
                    else if (seg_valid)
                        on_digit_nxt = seg_digit;
                    else
                        state_nxt = ST_IDLE;
                end
            end
            ST_OFF, ST_BLINK: begin
                if (ev) begin
                    if (seg_valid && (seg_digit == on_digit)) begin
                        state_nxt = ST_BLINK;
                    end else if (seg_valid) begin
                        state_nxt    = ST_ON;
                        on_digit_nxt = seg_digit;
                    end else if (seg_blank) begin
                        state_nxt = ST_BLINK;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_blinking = (state == ST_BLINK);
`else
    // Constant 0 for any legal BLINK_MAX.
    assign o_blinking = (BLINK_MAX == 0);
`endif

endmodule

// File: tb/tb_segment_reader.sv
// Randomised bench for segment_reader against a window/history based reference model.
module tb_segment_reader;

    localparam int S  = 4;
    localparam int BM = 64;
`ifdef SEGMENT_READER_BLINK_EN
    localparam int BLINK_EN = 1;
`else
    localparam int BLINK_EN = 0;
`endif
    localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2, M_BLINK = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] o_digit;
    logic       o_valid, o_blank, o_invalid, o_change, o_blinking;

    always #5 clk = ~clk;

    segment_reader #(.STABLE_CYCLES(S), .BLINK_MAX(BM)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_segment  (seg),
        .o_digit    (o_digit),
        .o_valid    (o_valid),
        .o_blank    (o_blank),
        .o_invalid  (o_invalid),
        .o_change   (o_change),
        .o_blinking (o_blinking)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int unsigned total = 0, passed = 0;
    int unsigned pulses = 0;
    bit          blink_seen = 0;
    bit          started = 0;

    // Reference model state
    logic [6:0] hist[$];
    int  m_digit, m_valid, m_blank, m_invalid, m_change, m_blinking;
    bit  m_seen;
    logic [6:0] m_acc;
    int  stage, m_d, since;

    function automatic int decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++)
            if (glyph[k] == p) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1;
            hist.delete();
            hist.push_front(7'h00);
            m_digit = 0; m_valid = 0; m_blank = 0; m_invalid = 0; m_change = 0; m_blinking = 0;
            m_seen = 0; m_acc = 7'h00; stage = M_IDLE; m_d = 0; since = 0;
        end else if (started) begin
            bit         acc, ev;
            logic [6:0] p;
            int         d;
            acc = (hist.size() >= S);
            p   = hist[0];
            if (acc)
                for (int k = 1; k < S; k++)
                    if (hist[k] != p) acc = 0;
            ev = 0;
            d  = decode(p);
            m_change = 0;
            if (acc) begin
                ev        = (p != m_acc);
                m_acc     = p;
                m_valid   = (d >= 0);
                m_blank   = (p == 7'h00);
                m_invalid = (d < 0) && (p != 7'h00);
                if (d >= 0) begin
                    m_change = !m_seen || (d != m_digit);
                    m_digit  = d;
                    m_seen   = 1;
                end
            end
            // Blink rules stated in terms of "cycles since last accepted change".
            if (ev) begin
                case (stage)
                    M_IDLE: if (d >= 0) begin stage = M_ON; m_d = d; end
                    M_ON: begin
                        if (p == 7'h00) stage = (since >= BM) ? M_IDLE : M_OFF;
                        else if (d >= 0) m_d = d;
                        else stage = M_IDLE;
                    end
                    default: begin
                        if (d >= 0 && d == m_d) stage = M_BLINK;
                        else if (d >= 0) begin stage = M_ON; m_d = d; end
                        else if (p == 7'h00) stage = M_BLINK;
                        else stage = M_IDLE;
                    end
                endcase
            end else if ((stage == M_OFF || stage == M_BLINK) && (since + 1 >= BM)) begin
                stage = M_IDLE;
            end
            since = ev ? 0 : since + 1;
            m_blinking = BLINK_EN ? int'(stage == M_BLINK) : 0;
            hist.push_front(seg);
            if (hist.size() > 16) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("digit",    o_digit,    m_digit);
            chk("valid",    o_valid,    m_valid);
            chk("blank",    o_blank,    m_blank);
            chk("invalid",  o_invalid,  m_invalid);
            chk("change",   o_change,   m_change);
            chk("blinking", o_blinking, m_blinking);
            chk("onehot",   int'(o_valid) + int'(o_blank) + int'(o_invalid) <= 1, 1);
            if (o_change) pulses++;
            if (o_blinking) blink_seen = 1;
        end
    end

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        seg   = 7'h00;
        repeat (2) @(negedge clk);

        // Latency and single o_change pulse
        rst_n = 1'b1;
        seg   = 7'h5B;
        repeat (4) @(negedge clk);
        chk("lat_before", o_valid, 0);
        @(negedge clk);
        chk("lat_valid", o_valid, 1);
        chk("lat_digit", o_digit, 2);
        chk("lat_change", o_change, 1);
        chk("lat_blank", o_blank, 0);
        chk("lat_invalid", o_invalid, 0);
        @(negedge clk);
        chk("lat_change_drop", o_change, 0);

        // Short glitch is filtered; invalid holds digit
        hold(7'h06, 8);
        chk("one_digit", o_digit, 1);
        pulses = 0;
        hold(7'h4F, 3);
        hold(7'h06, 6);
        chk("glitch_pulses", pulses, 0);
        chk("glitch_digit", o_digit, 1);
        hold(7'h49, 5);
        chk("inv_flag", o_invalid, 1);
        chk("inv_valid", o_valid, 0);
        chk("inv_digit", o_digit, 1);

        // Glyph sweep
        pulses = 0;
        for (int g = 0; g < 16; g++) hold(glyph[g], 6);
        chk("sweep_pulses", pulses, 16);
        chk("sweep_digit", o_digit, 15);
        hold(7'h00, 6);
        chk("blank_flag", o_blank, 1);
        chk("blank_digit", o_digit, 15);

        // Blinking with short halves, then timeout on a steady digit
        hold(7'h7F, 20);
        hold(7'h00, 20);
        hold(7'h7F, 8);
        chk("blink_on", o_blinking, BLINK_EN);
        hold(7'h7F, 70);
        chk("blink_timeout", o_blinking, 0);
        chk("blink_digit", o_digit, 8);

        // Long halves never blink
        blink_seen = 0;
        for (int r = 0; r < 2; r++) begin
            hold(7'h7F, 80);
            hold(7'h00, 80);
        end
        chk("slow_no_blink", blink_seen, 0);

        // Reset while blinking
        hold(7'h7F, 20);
        hold(7'h00, 20);
        hold(7'h7F, 10);
        chk("pre_rst_blink", o_blinking, BLINK_EN);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_digit", o_digit, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_blank", o_blank, 0);
        chk("rst_invalid", o_invalid, 0);
        chk("rst_change", o_change, 0);
        chk("rst_blinking", o_blinking, 0);
        rst_n = 1'b1;

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            int         kind, len;
            logic [6:0] p;
            kind = int'($urandom_range(0, 9));
            if (kind <= 5)      p = glyph[$urandom_range(0, 15)];
            else if (kind == 6) p = 7'h00;
            else if (kind == 7) p = 7'($urandom);
            else                p = seg;
            case ($urandom_range(0, 5))
                0:       len = int'($urandom_range(15, 40));
                1:       len = int'($urandom_range(55, 75));
                default: len = int'($urandom_range(1, 8));
            endcase
            if ($urandom_range(0, 7) == 0) begin
                logic [6:0] gp;
                int         half;
                gp   = glyph[$urandom_range(0, 15)];
                half = int'($urandom_range(8, 40));
                for (int b = 0; b < 3; b++) begin
                    hold(gp, half);
                    hold(7'h00, half);
                end
            end
            hold(p, len);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
